// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding,
// default memory base address and port identifiers.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr.sv
// Two-input round-robin pick: a lone requester wins outright; on contention
// the port that was not granted last time wins.
module rr_arbiter2
  import data_memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = PORT0;
    case (req)
      2'b01:   winner = PORT0;
      2'b10:   winner = PORT1;
      2'b11:   winner = ~last_grant;
      default: winner = PORT0;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer placing the CPU port (0) and the
// debug/DMA loader port (1) in front of a single-port word memory.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p0_req_i,
  input  logic                  p0_write_i,
  input  logic [DATA_WIDTH-1:0] p0_address_i,
  input  logic [DATA_WIDTH-1:0] p0_write_data_i,
  output logic                  p0_gnt_o,
  output logic                  p0_resp_o,
  output logic                  p0_err_o,
  output logic [DATA_WIDTH-1:0] p0_read_data_o,

  input  logic                  p1_req_i,
  input  logic                  p1_write_i,
  input  logic [DATA_WIDTH-1:0] p1_address_i,
  input  logic [DATA_WIDTH-1:0] p1_write_data_i,
  output logic                  p1_gnt_o,
  output logic                  p1_resp_o,
  output logic                  p1_err_o,
  output logic [DATA_WIDTH-1:0] p1_read_data_o,

  output logic                  mem_write_o,
  output logic                  mem_read_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,

  output state_t                dbg_state
);

  // Handshake: a port raises req with write/address/write_data and holds them
  // until the cycle gnt is high (the single ACCESS cycle); fields may change
  // after that edge. resp pulses for one cycle on the following cycle, with
  // err qualifying it and read_data valid alongside it.

  localparam logic [DATA_WIDTH-1:0] RANGE_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  // Borrow out of the subtraction means the address is below the base.
  function automatic logic addr_err(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off[DATA_WIDTH] || (off[DATA_WIDTH-1:0] >= RANGE_BYTES) || (a[1:0] != 2'b00);
  endfunction

  state_t                state_q, state_d;
  logic                  last_grant_q;
  logic                  winner_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic                  arb_valid;
  logic                  arb_winner;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .req        ({p1_req_i, p0_req_i}),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign sel_write = (arb_winner == PORT1) ? p1_write_i      : p0_write_i;
  assign sel_addr  = (arb_winner == PORT1) ? p1_address_i    : p0_address_i;
  assign sel_wdata = (arb_winner == PORT1) ? p1_write_data_i : p0_write_data_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT1;
      winner_q     <= PORT0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && arb_valid) begin
        winner_q <= arb_winner;
        write_q  <= sel_write;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        err_q    <= addr_err(sel_addr);
      end
      if (state_q == ST_ACCESS) begin
        last_grant_q <= winner_q;
        if (!err_q && !write_q) begin
          if (winner_q == PORT1) rdata1_q <= mem_data_i;
          else                   rdata0_q <= mem_data_i;
        end
      end
    end
  end

  // Memory strobes exist only in ACCESS, so nothing is committed elsewhere.
  always_comb begin
    p0_gnt_o         = 1'b0;
    p1_gnt_o         = 1'b0;
    p0_resp_o        = 1'b0;
    p1_resp_o        = 1'b0;
    p0_err_o         = 1'b0;
    p1_err_o         = 1'b0;
    mem_write_o      = 1'b0;
    mem_read_o       = 1'b0;
    mem_address_o    = '0;
    mem_write_data_o = '0;
    case (state_q)
      ST_ACCESS: begin
        p0_gnt_o = (winner_q == PORT0);
        p1_gnt_o = (winner_q == PORT1);
        if (!err_q) begin
          mem_write_o      = write_q;
          mem_read_o       = ~write_q;
          mem_address_o    = addr_q;
          mem_write_data_o = wdata_q;
        end
      end
      ST_RESP: begin
        p0_resp_o = (winner_q == PORT0);
        p1_resp_o = (winner_q == PORT1);
        p0_err_o  = (winner_q == PORT0) && err_q;
        p1_err_o  = (winner_q == PORT1) && err_q;
      end
      default: ;
    endcase
  end

  // Write and rejected responses present zero; otherwise the last read is held.
  logic resp_blank;
  assign resp_blank     = (state_q == ST_RESP) && (err_q || write_q);
  assign p0_read_data_o = (resp_blank && winner_q == PORT0) ? '0 : rdata0_q;
  assign p1_read_data_o = (resp_blank && winner_q == PORT1) ? '0 : rdata1_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: per-port expected queues filled at
// issue time from a reference memory, drained by a negedge monitor.
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  req, wr;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  gnt, resp, err;
  logic [31:0] rdata [2];
  logic        mem_write, mem_read;
  logic [31:0] mem_address, mem_write_data, mem_data;
  state_t      dbg_state;

  data_memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .p0_req_i         (req[0]),
    .p0_write_i       (wr[0]),
    .p0_address_i     (addr[0]),
    .p0_write_data_i  (wdata[0]),
    .p0_gnt_o         (gnt[0]),
    .p0_resp_o        (resp[0]),
    .p0_err_o         (err[0]),
    .p0_read_data_o   (rdata[0]),
    .p1_req_i         (req[1]),
    .p1_write_i       (wr[1]),
    .p1_address_i     (addr[1]),
    .p1_write_data_i  (wdata[1]),
    .p1_gnt_o         (gnt[1]),
    .p1_resp_o        (resp[1]),
    .p1_err_o         (err[1]),
    .p1_read_data_o   (rdata[1]),
    .mem_write_o      (mem_write),
    .mem_read_o       (mem_read),
    .mem_address_o    (mem_address),
    .mem_write_data_o (mem_write_data),
    .mem_data_i       (mem_data),
    .dbg_state        (dbg_state)
  );

  // ---------------- reference model helpers ----------------
  function automatic bit is_err(input logic [31:0] a);
    longint unsigned la;
    la = a;
    return (la < BASE) || (la >= longint'(BASE) + 4 * DEPTH) || (la % 4 != 0);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (mem_write && !is_err(mem_address)) begin
      mem[word_idx(mem_address)] <= mem_write_data;
    end
  end

  always_comb begin
    mem_data = 32'hBAD0_BAD0;
    if (!is_err(mem_address)) mem_data = mem[word_idx(mem_address)];
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          gnt_count [2];
  int          gnt_log[$];
  bit          log_gnts = 1'b0;
  logic [1:0]  gnt_prev;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  task automatic push_exp(input int p, input logic [32:0] e);
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic pop_exp(input int p, output bit ok, output logic [32:0] e);
    ok = 1'b0;
    e  = '0;
    if (p == 0 && exp_q0.size() > 0) begin ok = 1'b1; e = exp_q0.pop_front(); end
    if (p == 1 && exp_q1.size() > 0) begin ok = 1'b1; e = exp_q1.pop_front(); end
  endtask

  // ---------------- monitor ----------------
  initial begin
    gnt_count[0] = 0;
    gnt_count[1] = 0;
    gnt_prev     = 2'b00;
  end

  always @(negedge clk) begin
    if (reset) begin
      gnt_prev = 2'b00;
    end else begin
      if (gnt != 2'b00) begin
        int w;
        w = gnt[1] ? 1 : 0;
        check("gnt_onehot", 64'($countones(gnt)), 64'd1);
        gnt_count[w]++;
        if (log_gnts) gnt_log.push_back(w);
        if (!is_err(addr[w])) begin
          check("strobe_present", {62'd0, mem_read, mem_write}, {62'd0, ~wr[w], wr[w]});
          check("strobe_addr", 64'(mem_address), 64'(addr[w]));
          if (wr[w]) check("strobe_wdata", 64'(mem_write_data), 64'(wdata[w]));
        end
      end
      if (mem_read || mem_write) begin
        check("strobe_legal", 64'(is_err(mem_address)), 64'd0);
        check("strobe_with_gnt", 64'(gnt != 2'b00), 64'd1);
      end
      for (int p = 0; p < 2; p++) begin
        if (resp[p] || gnt_prev[p])
          check($sformatf("p%0d_resp_timing", p), 64'(resp[p]), 64'(gnt_prev[p]));
        if (resp[p]) begin
          bit          ok;
          logic [32:0] e;
          pop_exp(p, ok, e);
          if (!ok) begin
            checks++;
            errors++;
            $display("FAIL p%0d_unexpected_resp: actual=resp required=none", p);
          end else begin
            check($sformatf("p%0d_resp_err_data", p), 64'({err[p], rdata[p]}), 64'(e));
          end
        end
      end
      gnt_prev = gnt;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int gcyc, output int lat);
    int          start;
    bit          e;
    logic [31:0] rd;
    start    = cycle;
    req[p]   = 1'b1;
    wr[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    e  = is_err(a);
    rd = '0;
    if (!e) begin
      if (w) ref_mem[word_idx(a)] = d;
      else   rd = ref_mem[word_idx(a)];
    end
    push_exp(p, {e, rd});
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt[p]) begin
        lat = cycle - start;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL p%0d_gnt_timeout: actual=no gnt required=gnt within 30 cycles", p);
    end
    gcyc = cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic release_port(input int p);
    req[p] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt_resp_err"}, 64'({gnt, resp, err}), 64'd0);
    check({tag, "_rdata"}, {rdata[1], rdata[0]}, 64'd0);
    check({tag, "_mem_strobes"}, 64'({mem_write, mem_read}), 64'd0);
    check({tag, "_mem_bus"}, {mem_address, mem_write_data}, 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  function automatic logic [31:0] rand_addr(input int p);
    int kind;
    kind = $urandom_range(0, 9);
    case (kind)
      0:       return BASE + 32'(4 * (128 * p + $urandom_range(0, 127))) + 32'($urandom_range(1, 3));
      1:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
      2:       return BASE - 32'(4 * $urandom_range(1, 16));
      default: return BASE + 32'(4 * (128 * p + $urandom_range(0, 127)));
    endcase
  endfunction

  task automatic random_port(input int p, input int n);
    int g, l;
    for (int i = 0; i < n; i++) begin
      issue(p, 1'($urandom_range(0, 1)), rand_addr(p), $urandom, g, l);
      if ($urandom_range(0, 2) == 0) begin
        release_port(p);
        idle_cycles($urandom_range(1, 3));
      end
    end
    release_port(p);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int g, lat, g0, g1, g2, base_cnt;
    reset    = 1'b1;
    init_mem = 1'b1;
    req      = 2'b00;
    wr       = 2'b00;
    addr[0]  = '0; addr[1]  = '0;
    wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    idle_cycles(2);
    init_mem = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Contention from reset: both ports read continuously.
    @(posedge clk);
    #1;
    reset    = 1'b0;
    log_gnts = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b0, BASE + 32'(4 * (10 + i)), 32'd0, g0, lat);
        release_port(0);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, 1'b0, BASE + 32'(4 * (140 + i)), 32'd0, g1, lat);
        release_port(1);
      end
    join
    idle_cycles(4);
    log_gnts = 1'b0;
    check("contention_gnt_count", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < gnt_log.size(); i++)
      check($sformatf("contention_order_%0d", i), 64'(gnt_log[i]), 64'(i % 2));

    // Write then read back on port 0 from an idle arbiter.
    issue(0, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, g, lat);
    check("write_gnt_latency", 64'(lat), 64'd1);
    release_port(0);
    idle_cycles(1);
    issue(0, 1'b0, BASE + 32'h8, 32'd0, g, lat);
    check("read_gnt_latency", 64'(lat), 64'd1);
    release_port(0);
    idle_cycles(2);

    // Out-of-range write on port 1, then word 0 must be intact.
    issue(1, 1'b1, BASE + 32'h400, 32'hCAFE_F00D, g, lat);
    release_port(1);
    idle_cycles(1);
    issue(0, 1'b0, BASE, 32'd0, g, lat);
    release_port(0);
    idle_cycles(1);

    // Misaligned and below-base reads.
    issue(0, 1'b0, BASE + 32'h2, 32'd0, g, lat);
    release_port(0);
    idle_cycles(1);
    issue(0, 1'b0, 32'h1000_FFFC, 32'd0, g, lat);
    release_port(0);
    idle_cycles(2);

    // Reset asserted mid-ACCESS aborts the write and the response.
    req[0]   = 1'b1;
    wr[0]    = 1'b1;
    addr[0]  = BASE;
    wdata[0] = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_access", 64'({gnt[0], mem_write}), 64'b11);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("reset_in_access");
    req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(0, 1'b0, BASE, 32'd0, g, lat);
    release_port(0);
    idle_cycles(2);

    // Port 1 holds req across back-to-back transactions.
    base_cnt = gnt_count[1];
    issue(1, 1'b1, BASE + 32'(4 * 200), 32'h0BAD_F00D, g0, lat);
    issue(1, 1'b0, BASE + 32'(4 * 200), 32'd0, g1, lat);
    issue(1, 1'b0, BASE + 32'(4 * 201), 32'd0, g2, lat);
    release_port(1);
    idle_cycles(3);
    check("held_spacing_1", 64'(g1 - g0), 64'd3);
    check("held_spacing_2", 64'(g2 - g1), 64'd3);
    check("held_gnt_count", 64'(gnt_count[1] - base_cnt), 64'd3);

    // Randomized traffic on disjoint word regions per port.
    fork
      random_port(0, 30);
      random_port(1, 30);
    join
    idle_cycles(6);
    check("p0_queue_drained", 64'(exp_q0.size()), 64'd0);
    check("p1_queue_drained", 64'(exp_q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory (word-addressed, base 0x10010000).
- Port 0 is the CPU load/store path.
- Port 1 is the debug/DMA loader.
- Round-robin grant, one access at a time, registered responses.
- Address range/alignment checking before any memory strobe is issued.

Parameters:
DATA_WIDTH, 32, data and address width
MEMORY_DEPTH, 256, memory size in words; legal byte range is BASE_ADDR .. BASE_ADDR+4*MEMORY_DEPTH-1
BASE_ADDR, 32'h10010000, byte address of word 0

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
p0_req_i  input  1  port 0 request; held with its fields until p0_gnt_o seen
p0_write_i  input  1  1 = write, 0 = read
p0_address_i  input  DATA_WIDTH  byte address
p0_write_data_i  input  DATA_WIDTH  write data
p0_gnt_o  output  1  request accepted; high for exactly the ACCESS cycle
p0_resp_o  output  1  one-cycle completion pulse (reads and writes)
p0_err_o  output  1  qualifies p0_resp_o: access rejected
p0_read_data_o  output  DATA_WIDTH  read data, valid with p0_resp_o
p1_* (req_i, write_i, address_i, write_data_i, gnt_o, resp_o, err_o, read_data_o)  same as p0_*, for port 1
mem_write_o  output  1  to memory write enable
mem_read_o  output  1  to memory read enable
mem_address_o  output  DATA_WIDTH  to memory byte address
mem_write_data_o  output  DATA_WIDTH  to memory write data
mem_data_i  input  DATA_WIDTH  memory combinational read data

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async): state=IDLE, last_grant=1 (port 0 wins first contention); all gnt/resp/err/mem strobes 0; read_data registers 0; mem_address_o/mem_write_data_o 0.
- IDLE: no request -> stay. Otherwise latch winner id, write, address, write_data, and error flag at the edge -> ACCESS.
  - Winner: single requester wins; if both, port != last_grant wins.
  - Error flag = address outside legal range OR address[1:0] != 0.
- ACCESS (exactly 1 cycle): winner gnt_o=1; all req inputs ignored.
  - If no error: mem_address_o/mem_write_data_o driven from latched values; mem_write_o=latched write; mem_read_o=!latched write.
  - If error: mem strobes stay 0.
  - At edge: for non-error read, capture mem_data_i into winner read_data register; last_grant=winner; -> RESP.
- RESP (1 cycle): winner resp_o=1, err_o=latched error; read_data_o holds captured data (0 for writes/errors). -> IDLE.
- Latency: req seen in cycle N -> gnt N+1 -> write commits at end of N+1 -> resp N+2. Throughput 1 access per 3 cycles.
- read_data_o holds its value until that port's next read response.
- Requester may change fields after the edge where gnt_o was 1. A request still high in RESP is ignored; it is arbitrated again in IDLE.
- mem strobes are 0 in IDLE and RESP, so a memory write never occurs outside ACCESS.
- Reset asserted mid-ACCESS: strobes drop immediately. A write is not committed if reset is asserted before the edge. No resp is issued.
- Address arithmetic is unsigned 32-bit. Upper range compare must not overflow: use (address - BASE_ADDR) < 4*MEMORY_DEPTH, with borrow treated as out of range.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/RESP), BASE_ADDR default, port-id constants.
- One natural sub-module: rr_arbiter2 (2-input round-robin pick from req vector plus last_grant, combinational). FSM and datapath latches stay in the top.

Test Plan:
1. Write, then read: p0 write 0x10010008 data 0xDEADBEEF; after p0_resp_o, p0 read 0x10010008 -> gnt 1 cycle after req, resp 2 cycles after req, p0_read_data_o=0xDEADBEEF, err=0.
2. Contention: p0 and p1 both read continuously from reset -> grants alternate p0,p1,p0,p1; each resp carries correct data; never two gnts in one cycle.
3. Out of range: p1 write 0x10010400 (DEPTH=256) -> p1_resp_o with p1_err_o=1, mem_write_o never asserted; prior contents of word 0 unchanged.
4. Misaligned/below base: p0 read 0x10010002 and p0 read 0x1000FFFC -> err=1, read_data_o=0, mem_read_o stays 0.
5. Reset in ACCESS: p0 write 0x10010000 data 0x12345678; assert reset mid-ACCESS before the edge -> all outputs 0 immediately, no resp; readback after reset shows old value.
6. Held request: p1 holds req through RESP -> exactly one gnt per transaction; new grant 3 cycles apart.
